// File: rtl/battle_pkg.sv
// battle_pkg: shared types and sprite geometry for the tank battle pixel pipeline
package battle_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, EXPIRING} immunity_state_t;
  typedef logic [10:0] coord_t;
  localparam int OBJECT_W = 25;
  localparam int OBJECT_H = 25;
endpackage

// File: rtl/immunity_frame_ctrl_if.sv
// immunity_frame_ctrl_if: scan position, frame events and rectangle outputs of the immunity shield
interface immunity_frame_ctrl_if;
  import battle_pkg::*;
  coord_t pixelX;
  coord_t pixelY;
  logic startOfFrame;
  coord_t topLeftX;
  coord_t topLeftY;
  logic activate;
  logic cancel;
  coord_t offsetX;
  coord_t offsetY;
  logic InsideRectangle;
  logic immunityActive;
  modport master (
    output pixelX, pixelY, startOfFrame, topLeftX, topLeftY, activate, cancel,
    input offsetX, offsetY, InsideRectangle, immunityActive
  );
  modport slave (
    input pixelX, pixelY, startOfFrame, topLeftX, topLeftY, activate, cancel,
    output offsetX, offsetY, InsideRectangle, immunityActive
  );
endinterface

// File: rtl/frame_countdown.sv
// frame_countdown: loadable down-counter that saturates at zero
module frame_countdown #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = count == '0;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) count <= '0;
    else if (clear) count <= '0;
    else if (load) count <= load_value;
    else if (dec && !zero) count <= count - W'(1);
endmodule

// File: rtl/immunity_frame_ctrl.sv
// immunity_frame_ctrl: immunity shield lifetime, blink and frame-stable hit test
module immunity_frame_ctrl
  import battle_pkg::*;
#(
  parameter int OBJECT_WIDTH_X    = OBJECT_W,
  parameter int OBJECT_HEIGHT_Y   = OBJECT_H,
  parameter int DURATION_FRAMES   = 300,
  parameter int BLINK_FRAMES      = 90,
  parameter int BLINK_HALF_PERIOD = 8
) (
  input logic clk,
  input logic resetN,
  immunity_frame_ctrl_if.slave bus
);
  localparam int BW = $clog2(BLINK_HALF_PERIOD) + 1;
  immunity_state_t state, next;
  logic [9:0] frame_cnt, dec_val;
  logic cnt_zero, live, tick, visible, hit_x, hit_y, show;
  logic [BW-1:0] blink_cnt;
  coord_t latch_x, latch_y;
  frame_countdown #(.W(10)) u_cnt (
    .clk(clk),
    .resetN(resetN),
    .clear(bus.cancel),
    .load(bus.activate),
    .dec(tick && !bus.activate),
    .load_value(10'(DURATION_FRAMES)),
    .count(frame_cnt),
    .zero(cnt_zero)
  );
  always_comb begin
    live = state != IDLE;
    tick = bus.startOfFrame && live;
    dec_val = frame_cnt - {9'b0, !cnt_zero};
    next = bus.cancel ? IDLE :
           bus.activate ? ACTIVE :
           (tick && dec_val == '0) ? IDLE :
           (tick && state == ACTIVE && dec_val == 10'(BLINK_FRAMES)) ? EXPIRING : state;
    visible = state == ACTIVE || (state == EXPIRING && !blink_cnt[BW-1]);
    hit_x = {1'b0, bus.pixelX} >= {1'b0, latch_x} && {1'b0, bus.pixelX} < {1'b0, latch_x} + 12'(OBJECT_WIDTH_X);
    hit_y = {1'b0, bus.pixelY} >= {1'b0, latch_y} && {1'b0, bus.pixelY} < {1'b0, latch_y} + 12'(OBJECT_HEIGHT_Y);
    show = hit_x && hit_y && visible;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= next;
  // Position only moves at frame start (or on activation) so a frame never tears.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      latch_x <= '0;
      latch_y <= '0;
    end else if (bus.startOfFrame || bus.activate) begin
      latch_x <= bus.topLeftX;
      latch_y <= bus.topLeftY;
    end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) blink_cnt <= '0;
    else if (next == EXPIRING && state != EXPIRING) blink_cnt <= '0;
    else if (state == EXPIRING && tick) blink_cnt <= blink_cnt + BW'(1);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      bus.InsideRectangle <= 1'b0;
      bus.offsetX <= '0;
      bus.offsetY <= '0;
      bus.immunityActive <= 1'b0;
    end else begin
      bus.InsideRectangle <= show;
      bus.offsetX <= show ? bus.pixelX - latch_x : '0;
      bus.offsetY <= show ? bus.pixelY - latch_y : '0;
      bus.immunityActive <= next != IDLE;
    end
endmodule

// File: tb/tb_immunity_frame_ctrl.sv
// tb_immunity_frame_ctrl: directed scoreboard bench for the immunity shield controller
module tb_immunity_frame_ctrl;
  import battle_pkg::*;
  typedef struct packed {logic in; coord_t x; coord_t y;} exp_t;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  immunity_frame_ctrl_if bus();
  immunity_frame_ctrl dut (.clk(clk), .resetN(resetN), .bus(bus));
  int checks = 0;
  int errors = 0;
  int mlx = 0;
  int mly = 0;
  exp_t sb[$];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic frame();
    bus.startOfFrame = 1'b1;
    mlx = int'(bus.topLeftX);
    mly = int'(bus.topLeftY);
    step();
    bus.startOfFrame = 1'b0;
  endtask
  task automatic act();
    bus.activate = 1'b1;
    mlx = int'(bus.topLeftX);
    mly = int'(bus.topLeftY);
    step();
    bus.activate = 1'b0;
  endtask
  task automatic probe(input int x, input int y, input logic vis);
    exp_t e;
    logic in;
    in = vis && x >= mlx && x < mlx + 25 && y >= mly && y < mly + 25;
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    sb.push_back('{in, in ? 11'(x - mlx) : 11'd0, in ? 11'(y - mly) : 11'd0});
    step();
    e = sb.pop_front();
    chk("inside", 32'(bus.InsideRectangle), 32'(e.in));
    chk("offsetX", 32'(bus.offsetX), 32'(e.x));
    chk("offsetY", 32'(bus.offsetY), 32'(e.y));
  endtask
  initial begin
    bus.pixelX = '0;
    bus.pixelY = '0;
    bus.startOfFrame = 1'b0;
    bus.topLeftX = 11'd100;
    bus.topLeftY = 11'd200;
    bus.activate = 1'b0;
    bus.cancel = 1'b0;
    step();
    step();
    chk("rst_inside", 32'(bus.InsideRectangle), 0);
    chk("rst_offx", 32'(bus.offsetX), 0);
    chk("rst_offy", 32'(bus.offsetY), 0);
    chk("rst_active", 32'(bus.immunityActive), 0);
    resetN = 1'b1;
    step();
    probe(112, 210, 1'b0);
    act();
    chk("act_active", 32'(bus.immunityActive), 1);
    chk("act_cnt", 32'(dut.frame_cnt), 300);
    probe(112, 210, 1'b1);
    probe(125, 210, 1'b1);
    probe(124, 224, 1'b1);
    probe(99, 210, 1'b1);
    probe(112, 225, 1'b1);
    bus.topLeftX = 11'd140;
    probe(112, 210, 1'b1);
    probe(145, 210, 1'b1);
    frame();
    probe(145, 210, 1'b1);
    probe(112, 210, 1'b1);
    bus.topLeftX = 11'd100;
    frame();
    for (int i = 0; i < 207; i++) frame();
    chk("f209_state", 32'(dut.state), 32'(ACTIVE));
    chk("f209_cnt", 32'(dut.frame_cnt), 91);
    frame();
    chk("f210_state", 32'(dut.state), 32'(EXPIRING));
    chk("f210_cnt", 32'(dut.frame_cnt), 90);
    chk("f210_active", 32'(bus.immunityActive), 1);
    for (int k = 0; k < 90; k++) begin
      probe(112, 210, ((k / 8) % 2) == 0);
      chk("blink_active", 32'(bus.immunityActive), 1);
      frame();
    end
    chk("end_active", 32'(bus.immunityActive), 0);
    chk("end_state", 32'(dut.state), 32'(IDLE));
    chk("end_cnt", 32'(dut.frame_cnt), 0);
    probe(112, 210, 1'b0);
    act();
    for (int i = 0; i < 150; i++) frame();
    chk("mid_cnt", 32'(dut.frame_cnt), 150);
    probe(112, 210, 1'b1);
    #2 resetN = 1'b0;
    #1;
    chk("arst_inside", 32'(bus.InsideRectangle), 0);
    chk("arst_offx", 32'(bus.offsetX), 0);
    chk("arst_offy", 32'(bus.offsetY), 0);
    chk("arst_active", 32'(bus.immunityActive), 0);
    chk("arst_cnt", 32'(dut.frame_cnt), 0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    step();
    step();
    resetN = 1'b1;
    mlx = 0;
    mly = 0;
    probe(112, 210, 1'b0);
    probe(5, 5, 1'b0);
    act();
    chk("act2_active", 32'(bus.immunityActive), 1);
    bus.activate = 1'b1;
    bus.cancel = 1'b1;
    step();
    bus.activate = 1'b0;
    bus.cancel = 1'b0;
    chk("ac_state", 32'(dut.state), 32'(IDLE));
    chk("ac_active", 32'(bus.immunityActive), 0);
    chk("ac_cnt", 32'(dut.frame_cnt), 0);
    act();
    for (int i = 0; i < 295; i++) frame();
    chk("c5_state", 32'(dut.state), 32'(EXPIRING));
    chk("c5_cnt", 32'(dut.frame_cnt), 5);
    bus.activate = 1'b1;
    bus.startOfFrame = 1'b1;
    mlx = int'(bus.topLeftX);
    mly = int'(bus.topLeftY);
    step();
    bus.activate = 1'b0;
    bus.startOfFrame = 1'b0;
    chk("rl_cnt", 32'(dut.frame_cnt), 300);
    chk("rl_state", 32'(dut.state), 32'(ACTIVE));
    chk("rl_active", 32'(bus.immunityActive), 1);
    for (int i = 0; i < 20; i++) begin
      probe(112, 210, 1'b1);
      frame();
    end
    chk("rl_cnt20", 32'(dut.frame_cnt), 280);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk("cx_state", 32'(dut.state), 32'(IDLE));
    chk("cx_active", 32'(bus.immunityActive), 0);
    probe(112, 210, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
